// File: rtl/gpio_pad_ctrl_pkg.sv
// gpio_pad_ctrl_pkg
// Shared types and constants for the gpio_pad_ctrl pad control slice:
//   state_e            direction FSM states
//   PULL_NONE/DOWN/UP  cfg_pull encodings
//   DEF_*              default parameter values
package gpio_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_e;

  localparam logic [1:0] PULL_NONE = 2'b00;
  localparam logic [1:0] PULL_DOWN = 2'b01;
  localparam logic [1:0] PULL_UP   = 2'b10;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_W       = 8;
  localparam int DEF_TURN_CYCLES = 2;

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if
// Core-side configuration/status bundle between the GPIO register bank
// (master) and one gpio_pad_ctrl instance (slave).
//   cfg_*        configuration from the register bank
//   irq_clr      clears the sticky edge interrupt
//   data_in      filtered pad value
//   irq          sticky edge interrupt
//   busy         direction turnaround in progress
interface gpio_pad_ctrl_if
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int DEB_W = DEF_DEB_W
);
  logic             cfg_dir_out;
  logic             cfg_data_out;
  logic             cfg_ie;
  logic [1:0]       cfg_pull;
  logic             cfg_slew;
  logic             cfg_schmitt;
  logic [DEB_W-1:0] cfg_deb_len;
  logic             cfg_irq_rise;
  logic             cfg_irq_fall;
  logic             irq_clr;
  logic             data_in;
  logic             irq;
  logic             busy;

  modport master (
    output cfg_dir_out, cfg_data_out, cfg_ie, cfg_pull, cfg_slew, cfg_schmitt,
           cfg_deb_len, cfg_irq_rise, cfg_irq_fall, irq_clr,
    input  data_in, irq, busy
  );

  modport slave (
    input  cfg_dir_out, cfg_data_out, cfg_ie, cfg_pull, cfg_slew, cfg_schmitt,
           cfg_deb_len, cfg_irq_rise, cfg_irq_fall, irq_clr,
    output data_in, irq, busy
  );
endinterface

// File: rtl/gpio_pad_ctrl_infilt.sv
// gpio_pad_ctrl_infilt
// Pad input path: SYNC_STAGES-flop synchroniser, debounce filter, edge detect.
// Build option: GPIO_PAD_CTRL_DEBOUNCE_EN builds the debounce counter; without
// it the filter register simply follows the synchroniser output every cycle.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   mask_i         input disabled: synchroniser, filter and counter held at 0
//   pad_y_i        raw asynchronous pad input
//   deb_len_i      debounce length (0 treated as 1)
//   f_o            filtered value
//   rise_o/fall_o  single-cycle strobes, valid on the edge f_o updates
module gpio_pad_ctrl_infilt
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_W       = DEF_DEB_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mask_i,
  input  logic             pad_y_i,
  input  logic [DEB_W-1:0] deb_len_i,
  output logic             f_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   f_q, f_d;
  logic                   upd;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = mask_i ? '0 : {sync_q[SYNC_STAGES-2:0], pad_y_i};
  end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W:0]   len_eff;
  logic [DEB_W:0]   cnt_inc;

  assign len_eff = (deb_len_i == '0) ? (DEB_W+1)'(1) : {1'b0, deb_len_i};
  assign cnt_inc = {1'b0, cnt_q} + (DEB_W+1)'(1);

  // cnt_q counts earlier consecutive mismatches; this edge is one more.
  always_comb begin
    cnt_d = cnt_q;
    upd   = 1'b0;
    if (mask_i || (s == f_q)) begin
      cnt_d = '0;
    end else if (cnt_inc >= len_eff) begin
      upd   = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc[DEB_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_deb_len;
  assign unused_deb_len = ^deb_len_i;
  assign upd = ~mask_i & (s != f_q);
`endif

  // Masking forces f to 0 without going through upd, so no edge is reported.
  always_comb begin
    f_d = f_q;
    if (mask_i)   f_d = 1'b0;
    else if (upd) f_d = s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      f_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      f_q    <= f_d;
    end
  end

  assign f_o    = f_q;
  assign rise_o = upd & s;
  assign fall_o = upd & ~s;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Control stage for one bidirectional pad cell: direction FSM with dead-time
// turnaround, registered pad controls, filtered input and sticky edge irq.
// Build option: GPIO_PAD_CTRL_DEBOUNCE_EN enables the input debounce counter.
// Ports:
//   CLK, RESETN           clock, asynchronous active-low reset
//   bus (slave)           cfg_*/irq_clr in, data_in/irq/busy out
//   PAD_A/OE/IE/PU/PD/CS/SL  registered pad cell controls
//   PAD_Y                 pad input buffer output (asynchronous)
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_W       = DEF_DEB_W,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic            CLK,
  input  logic            RESETN,
  gpio_pad_ctrl_if.slave  bus,
  output logic            PAD_A,
  output logic            PAD_OE,
  output logic            PAD_IE,
  output logic            PAD_PU,
  output logic            PAD_PD,
  output logic            PAD_CS,
  output logic            PAD_SL,
  input  logic            PAD_Y
);

  localparam int              CNT_W     = $clog2(TURN_CYCLES + 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oe_q, oe_d, pu_q, pu_d, pd_q, pd_d, busy_q, busy_d;
  logic             a_q, ie_q, cs_q, sl_q;
  logic             irq_q, irq_d;
  logic             f, rise, fall;

  gpio_pad_ctrl_infilt #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W)
  ) u_infilt (
    .clk_i     (CLK),
    .rst_ni    (RESETN),
    .mask_i    (~ie_q),
    .pad_y_i   (PAD_Y),
    .deb_len_i (bus.cfg_deb_len),
    .f_o       (f),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // A direction request always wins over the count, so an abort reloads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IN: begin
        if (bus.cfg_dir_out) begin
          state_d = ST_TURN_OUT;
          cnt_d   = TURN_LOAD;
        end
      end
      ST_TURN_OUT: begin
        if (!bus.cfg_dir_out) begin
          state_d = ST_TURN_IN;
          cnt_d   = TURN_LOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_OUT: begin
        if (!bus.cfg_dir_out) begin
          state_d = ST_TURN_IN;
          cnt_d   = TURN_LOAD;
        end
      end
      ST_TURN_IN: begin
        if (bus.cfg_dir_out) begin
          state_d = ST_TURN_OUT;
          cnt_d   = TURN_LOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_IN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IN;
        cnt_d   = '0;
      end
    endcase

    // Outputs decoded from the next state so they register with it.
    oe_d   = (state_d == ST_OUT);
    busy_d = (state_d == ST_TURN_OUT) || (state_d == ST_TURN_IN);
    pu_d   = (state_d == ST_IN) && (bus.cfg_pull == PULL_UP);
    pd_d   = (state_d == ST_IN) && (bus.cfg_pull == PULL_DOWN);

    // Set has priority over clear.
    irq_d = (rise & bus.cfg_irq_rise) | (fall & bus.cfg_irq_fall) |
            (irq_q & ~bus.irq_clr);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IN;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      pu_q    <= 1'b0;
      pd_q    <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= 1'b0;
      ie_q    <= 1'b0;
      cs_q    <= 1'b0;
      sl_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      busy_q  <= busy_d;
      a_q     <= bus.cfg_data_out;
      ie_q    <= bus.cfg_ie;
      cs_q    <= bus.cfg_schmitt;
      sl_q    <= bus.cfg_slew;
      irq_q   <= irq_d;
    end
  end

  assign PAD_A       = a_q;
  assign PAD_OE      = oe_q;
  assign PAD_IE      = ie_q;
  assign PAD_PU      = pu_q;
  assign PAD_PD      = pd_q;
  assign PAD_CS      = cs_q;
  assign PAD_SL      = sl_q;
  assign bus.data_in = f;
  assign bus.irq     = irq_q;
  assign bus.busy    = busy_q;

endmodule
